// File: rtl/mem_perf_monitor_pkg.sv
// Shared types and helpers for the memory-port performance monitor.
// Optional data comparison is enabled by defining MEM_PERF_DATACHK_EN.
package mem_perf_pkg;

  typedef enum logic {
    IDLE,
    BUSY
  } chan_state_t;

  localparam int ERR_PERF    = 0;
  localparam int ERR_DROP    = 1;
  localparam int ERR_SPUR    = 2;
  localparam int ERR_TIMEOUT = 3;
  localparam int ERR_DATA    = 4;
  localparam int ERR_W       = 5;

  // 65-bit sum so a full-width counter can never wrap before clamping
  function automatic logic [63:0] sat_add(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [63:0] max
  );
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[63:0];
  endfunction

endpackage

// File: rtl/mem_perf_monitor_if.sv
// Monitored memory-port bundle, one bit (or DATA_W slice) per channel.
// The monitor only observes, so it takes the slave view.
interface mem_perf_monitor_if #(
  parameter int NUM_CH = 1,
  parameter int DATA_W = 16
);
  logic [NUM_CH-1:0]        rd;
  logic [NUM_CH-1:0]        wr;
  logic [NUM_CH-1:0]        stall;
  logic [NUM_CH-1:0]        done;
  logic [NUM_CH-1:0]        cache_hit;
  logic [NUM_CH*DATA_W-1:0] data_out;
  logic [NUM_CH*DATA_W-1:0] data_ref;

  modport master (
    output rd, wr, stall, done,
    output cache_hit, data_out, data_ref
  );

  modport slave (
    input rd, wr, stall, done,
    input cache_hit, data_out, data_ref
  );
endinterface

// File: rtl/mem_perf_monitor_chan.sv
// Per-channel request tracker: FSM, latency counter, window checks.
// Data comparator exists only with MEM_PERF_DATACHK_EN defined.
module mem_perf_chan
  import mem_perf_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int LAT_W        = 8,
  parameter int HIT_MAX_LAT  = 2,
  parameter int MISS_MIN_LAT = 3,
  parameter int MISS_MAX_LAT = 20,
  parameter int TIMEOUT      = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd,
  input  logic             wr,
  input  logic             stall,
  input  logic             done,
  input  logic             cache_hit,
`ifdef MEM_PERF_DATACHK_EN
  input  logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_ref,
`endif
  output logic             accept,
  output logic             reply,
  output logic             hit,
  output logic [ERR_W-1:0] err
);

  localparam logic [LAT_W-1:0] TMO = LAT_W'(TIMEOUT);

  chan_state_t      state;
  logic [LAT_W-1:0] lat;
  logic [LAT_W-1:0] l_now;
  logic             req;
  logic             busy;
  logic             hit_ok;
  logic             miss_ok;

  assign req    = rd | wr;
  assign busy   = (state == BUSY);
  assign accept = !busy && req && !stall;
  assign l_now  = busy ? lat + 1'b1 : LAT_W'(1);

  assign hit_ok  = l_now <= LAT_W'(HIT_MAX_LAT);
  assign miss_ok = (l_now >= LAT_W'(MISS_MIN_LAT))
                && (l_now <= LAT_W'(MISS_MAX_LAT));

  always_comb begin
    reply = done && (accept || busy);
    hit   = reply && cache_hit;
    err   = '0;
    err[ERR_PERF]    = reply && (cache_hit ? !hit_ok : !miss_ok);
    err[ERR_DROP]    = busy && !done && !req;
    err[ERR_SPUR]    = !busy && done && !accept;
    err[ERR_TIMEOUT] = busy && !done && req && (l_now == TMO);
`ifdef MEM_PERF_DATACHK_EN
    err[ERR_DATA]    = reply && rd && (data_out != data_ref);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      lat   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && !done) begin
            state <= BUSY;
            lat   <= LAT_W'(1);
          end
        end
        BUSY: begin
          if (done || !req || l_now == TMO) begin
            state <= IDLE;
            lat   <= '0;
          end else begin
            lat <= (lat >= TMO) ? TMO : l_now;
          end
        end
        default: begin
          state <= IDLE;
          lat   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_perf_monitor.sv
// Multi-channel memory-port monitor: saturating stats and sticky errors.
// Define MEM_PERF_DATACHK_EN to compare read data against a reference.
module mem_perf_monitor
  import mem_perf_pkg::*;
#(
  parameter int NUM_CH       = 1,
  parameter int DATA_W       = 16,
  parameter int CNT_W        = 32,
  parameter int LAT_W        = 8,
  parameter int HIT_MAX_LAT  = 2,
  parameter int MISS_MIN_LAT = 3,
  parameter int MISS_MAX_LAT = 20,
  parameter int TIMEOUT      = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  mem_perf_monitor_if.slave       bus,
  output logic [CNT_W-1:0]        cycle_cnt,
  output logic [CNT_W-1:0]        req_cnt,
  output logic [CNT_W-1:0]        reply_cnt,
  output logic [CNT_W-1:0]        hit_cnt,
  output logic [CNT_W-1:0]        err_cnt,
  output logic [NUM_CH*ERR_W-1:0] err_flags,
  output logic                    pass
);

  localparam int          PC_W = 16;
  localparam logic [63:0] CMAX = 64'({CNT_W{1'b1}});

  logic [NUM_CH-1:0]       acc_v;
  logic [NUM_CH-1:0]       rep_v;
  logic [NUM_CH-1:0]       hit_v;
  logic [NUM_CH*ERR_W-1:0] err_v;
  logic [PC_W-1:0]         n_acc;
  logic [PC_W-1:0]         n_rep;
  logic [PC_W-1:0]         n_hit;
  logic [PC_W-1:0]         n_err;
  logic [CNT_W-1:0]        err_nxt;

  function automatic logic [CNT_W-1:0] cnt_add(
    input logic [CNT_W-1:0] c,
    input logic [PC_W-1:0]  n
  );
    return CNT_W'(sat_add(64'(c), 64'(n), CMAX));
  endfunction

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    mem_perf_chan #(
      .DATA_W       (DATA_W),
      .LAT_W        (LAT_W),
      .HIT_MAX_LAT  (HIT_MAX_LAT),
      .MISS_MIN_LAT (MISS_MIN_LAT),
      .MISS_MAX_LAT (MISS_MAX_LAT),
      .TIMEOUT      (TIMEOUT)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .rd        (bus.rd[g]),
      .wr        (bus.wr[g]),
      .stall     (bus.stall[g]),
      .done      (bus.done[g]),
      .cache_hit (bus.cache_hit[g]),
`ifdef MEM_PERF_DATACHK_EN
      .data_out  (bus.data_out[g*DATA_W +: DATA_W]),
      .data_ref  (bus.data_ref[g*DATA_W +: DATA_W]),
`endif
      .accept    (acc_v[g]),
      .reply     (rep_v[g]),
      .hit       (hit_v[g]),
      .err       (err_v[g*ERR_W +: ERR_W])
    );
  end

`ifndef MEM_PERF_DATACHK_EN
  logic unused_data;
  assign unused_data = ^{bus.data_out, bus.data_ref};
`endif

  always_comb begin
    n_acc = '0;
    n_rep = '0;
    n_hit = '0;
    n_err = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      n_acc = n_acc + PC_W'(acc_v[i]);
      n_rep = n_rep + PC_W'(rep_v[i]);
      n_hit = n_hit + PC_W'(hit_v[i]);
    end
    for (int i = 0; i < NUM_CH*ERR_W; i++)
      n_err = n_err + PC_W'(err_v[i]);
    err_nxt = cnt_add(err_cnt, n_err);
  end

  // clr drops this cycle's events along with the history
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cycle_cnt <= '0;
      req_cnt   <= '0;
      reply_cnt <= '0;
      hit_cnt   <= '0;
      err_cnt   <= '0;
      err_flags <= '0;
      pass      <= 1'b1;
    end else begin
      cycle_cnt <= cnt_add(cycle_cnt, PC_W'(1));
      req_cnt   <= cnt_add(req_cnt, n_acc);
      reply_cnt <= cnt_add(reply_cnt, n_rep);
      hit_cnt   <= cnt_add(hit_cnt, n_hit);
      err_cnt   <= err_nxt;
      err_flags <= err_flags | err_v;
      pass      <= (err_nxt == '0);
    end
  end

endmodule
